// File: rtl/rv32i_enc_pkg.sv
// Shared op codes, opcode/funct constants and helpers for the RV32I instruction encoder.
// Consumed by rv32i_field_packer and rv32i_instr_encoder.
package rv32i_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_ADDI  = 4'd3,
        OP_LW    = 4'd4,
        OP_SW    = 4'd5,
        OP_BEQ   = 4'd6,
        OP_LUI   = 4'd7,
        OP_AUIPC = 4'd8,
        OP_JAL   = 4'd9,
        OP_JALR  = 4'd10
    } enc_op_e;

    localparam logic [3:0] OP_LAST = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_JALR = 3'd0;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/rv32i_field_packer.sv
// Combinational op + fields -> RV32I word, with op-legality and immediate-range flags.
// The immediate range check exists only when ENC_RANGE_CHECK_EN is defined.
module rv32i_field_packer
    import rv32i_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal,
    output logic        range_ok
);

    enc_op_e op_e;

    assign op_e  = enc_op_e'(op);
    assign legal = is_legal_op(op);

    // NOTE: every output of a combinational block gets a default before the case,
    // so an uncovered branch can never infer a latch.
    always_comb begin
        word = NOP_WORD;
        case (op_e)
            OP_ADD:   word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SUB:   word = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_AND:   word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OP_ADDI:  word = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
            OP_LW:    word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
            OP_SW:    word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
            OP_BEQ:   word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                              imm[4:1], imm[11], OPC_BRANCH};
            OP_LUI:   word = {imm[31:12], rd, OPC_LUI};
            OP_AUIPC: word = {imm[31:12], rd, OPC_AUIPC};
            OP_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            OP_JALR:  word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
            default:  word = NOP_WORD;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic i_ok;
    logic b_ok;
    logic j_ok;
    logic u_ok;

    // Sign-extension test: all bits above the field's sign bit must equal it.
    assign i_ok = (imm[31:11] == {21{imm[11]}});
    assign b_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign j_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
    assign u_ok = (imm[11:0] == 12'h000);

    always_comb begin
        range_ok = 1'b1;
        case (op_e)
            OP_ADDI, OP_LW, OP_SW, OP_JALR: range_ok = i_ok;
            OP_BEQ:                         range_ok = b_ok;
            OP_JAL:                         range_ok = j_ok;
            OP_LUI, OP_AUIPC:               range_ok = u_ok;
            default:                        range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Single-entry output register streaming encoded RV32I words with target addresses.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_word,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [CNT_W-1:0]  instr_count,
    output logic              err_illegal,
    output logic              err_range
);

    logic              valid_q, valid_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_illegal_q, err_illegal_d;

    logic [31:0]       packed_word;
    logic              op_legal;
    logic              imm_ok;
    logic              accept;
    logic              drain;
    logic [ADDR_W-1:0] pc_base;

    rv32i_field_packer u_packer (
        .op       (req_op),
        .rd       (req_rd),
        .rs1      (req_rs1),
        .rs2      (req_rs2),
        .imm      (req_imm),
        .word     (packed_word),
        .legal    (op_legal),
        .range_ok (imm_ok)
    );

    assign req_ready = !valid_q || instr_ready;
    assign accept    = req_valid && req_ready;
    assign drain     = valid_q && instr_ready;
    // A same-cycle load overrides the counter for the word being captured.
    assign pc_base   = addr_load ? addr_value : pc_q;

    always_comb begin
        valid_d       = valid_q;
        word_d        = word_q;
        addr_d        = addr_q;
        pc_d          = pc_q;
        count_d       = count_q;
        err_illegal_d = 1'b0;

        if (drain && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
        if (drain) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            valid_d       = 1'b1;
            addr_d        = pc_base;
            pc_d          = pc_base + ADDR_W'(4);
            err_illegal_d = !op_legal;
            word_d        = (op_legal && imm_ok) ? packed_word : NOP_WORD;
        end else if (addr_load) begin
            pc_d = addr_value;
        end
    end

    // NOTE: state registers use non-blocking assignments under an asynchronous
    // active-low reset so every flop samples the pre-edge value of its _d input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            word_q        <= '0;
            addr_q        <= BASE_ADDR;
            pc_q          <= BASE_ADDR;
            count_q       <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            word_q        <= word_d;
            addr_q        <= addr_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            err_illegal_q <= err_illegal_d;
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic err_range_q, err_range_d;

    // Sticky until reset; an illegal op is reported separately and not as a range error.
    always_comb begin
        err_range_d = err_range_q | (accept && op_legal && !imm_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range_q <= 1'b0;
        end else begin
            err_range_q <= err_range_d;
        end
    end

    assign err_range = err_range_q;
`else
    assign err_range = 1'b0;
`endif

    assign instr_valid = valid_q;
    assign instr_word  = word_q;
    assign instr_addr  = addr_q;
    assign instr_count = count_q;
    assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: behavioural model + per-cycle compare,
// plus hand-computed literal words/addresses checked at each output handshake.
module tb_rv32i_instr_encoder;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_op = '0;
    logic [4:0]        req_rd = '0;
    logic [4:0]        req_rs1 = '0;
    logic [4:0]        req_rs2 = '0;
    logic [31:0]       req_imm = '0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_value = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b1;
    logic [31:0]       instr_word;
    logic [ADDR_W-1:0] instr_addr;
    logic [CNT_W-1:0]  instr_count;
    logic              err_illegal;
    logic              err_range;

    rv32i_instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h0000_0000),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .addr_load   (addr_load),
        .addr_value  (addr_value),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_word  (instr_word),
        .instr_addr  (instr_addr),
        .instr_count (instr_count),
        .err_illegal (err_illegal),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ill_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_encode(input int op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
        logic [31:0] d, s1, s2;
        d  = 32'(rd)  << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        case (op)
            0:  return 32'h33 | d | s1 | s2;
            1:  return 32'h4000_0033 | d | s1 | s2;
            2:  return 32'h33 | (32'd7 << 12) | d | s1 | s2;
            3:  return 32'h13 | d | s1 | ((imm & 32'hFFF) << 20);
            4:  return 32'h03 | (32'd2 << 12) | d | s1 | ((imm & 32'hFFF) << 20);
            5:  return 32'h23 | (32'd2 << 12) | s1 | s2
                       | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            6:  return 32'h63 | s1 | s2
                       | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                       | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            7:  return 32'h37 | d | (imm & 32'hFFFF_F000);
            8:  return 32'h17 | d | (imm & 32'hFFFF_F000);
            9:  return 32'h6F | d
                       | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            10: return 32'h67 | d | s1 | ((imm & 32'hFFF) << 20);
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic bit ref_imm_ok(input int op, input logic [31:0] imm);
`ifdef ENC_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
        case (op)
            3, 4, 5, 10: return (s >= -2048) && (s <= 2047);
            6:           return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            9:           return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
            7, 8:        return (imm % 4096) == 0;
            default:     return 1'b1;
        endcase
`else
        return (op >= 0) || (imm === imm);
`endif
    endfunction

    bit          m_valid = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_pc = '0;
    int          m_count = 0;
    bit          m_ill = 0;
    bit          m_range = 0;
    bit          m_acc = 0;
    bit          m_rdy;
    logic [31:0] m_base;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_word = '0; m_addr = '0; m_pc = '0;
            m_count = 0; m_ill = 0; m_range = 0; m_acc = 0;
        end else begin
            m_rdy = !m_valid || instr_ready;
            m_acc = req_valid && m_rdy;
            if (m_valid && instr_ready) begin
                if (m_count < (1 << CNT_W) - 1) m_count++;
                m_valid = 0;
            end
            m_ill  = 0;
            m_base = addr_load ? addr_value : m_pc;
            if (m_acc) begin
                m_valid = 1;
                m_addr  = m_base;
                m_pc    = m_base + 32'd4;
                if (int'(req_op) > 10) begin
                    m_ill  = 1;
                    m_word = 32'h0000_0013;
                end else if (!ref_imm_ok(int'(req_op), req_imm)) begin
                    m_range = 1;
                    m_word  = 32'h0000_0013;
                end else begin
                    m_word = ref_encode(int'(req_op), req_rd, req_rs1, req_rs2, req_imm);
                end
            end else if (addr_load) begin
                m_pc = addr_value;
            end
        end
    end

    // ---------------- literal expectations per handshake ----------------
    typedef struct {
        bit          has_lit;
        logic [31:0] word;
        logic [31:0] addr;
    } lit_t;
    lit_t lit_q[$];

    always @(negedge clk) begin
        check("req_ready",   32'(req_ready),   32'(!m_valid || instr_ready));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr_count", 32'(instr_count), 32'(m_count));
        check("err_illegal", 32'(err_illegal), 32'(m_ill));
        check("err_range",   32'(err_range),   32'(m_range));
        if (m_valid) begin
            check("instr_word", instr_word, m_word);
            check("instr_addr", instr_addr, m_addr);
        end
        if (err_illegal) ill_seen++;
        if (instr_valid && instr_ready) begin
            if (lit_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL handshake_queue: unexpected word 0x%08h at %0t", instr_word, $time);
            end else begin
                lit_t e;
                e = lit_q.pop_front();
                if (e.has_lit) begin
                    check("lit_word", instr_word, e.word);
                    check("lit_addr", instr_addr, e.addr);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm,
                         input bit has_lit, input logic [31:0] lw, input logic [31:0] la,
                         input bit ld = 0, input logic [31:0] ldv = '0);
        lit_t e;
        e.has_lit = has_lit; e.word = lw; e.addr = la;
        lit_q.push_back(e);
        req_op = 4'(op); req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        addr_load = ld; addr_value = ldv;
        req_valid = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_acc) break;
        end
        if (!m_acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: request not accepted within 50 cycles at %0t", $time);
        end
        req_valid = 1'b0;
        addr_load = 1'b0;
    endtask

    task automatic send(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input bit has_lit, input logic [31:0] lw, input logic [31:0] la,
                        input bit ld = 0, input logic [31:0] ldv = '0);
        drive(op, rd, rs1, rs2, imm, has_lit, lw, la, ld, ldv);
        wait_accept();
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr",  instr_addr,       32'h0);
        check("rst_word",  instr_word,       32'h0);
        check("rst_count", 32'(instr_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(0,  0, 1, 2, 32'd0,        1, 32'h0020_8033, 32'd0);
        send(1,  0, 1, 2, 32'd0,        1, 32'h4020_8033, 32'd4);
        send(3,  1, 1, 0, 32'd2,        1, 32'h0020_8093, 32'd8);
        send(4,  1, 0, 0, 32'd2,        1, 32'h0020_2083, 32'd12);
        send(6,  0, 1, 2, 32'd0,        1, 32'h0020_8063, 32'd16);
        send(7,  1, 0, 0, 32'h1234_5000, 1, 32'h1234_50B7, 32'd20);
        send(8,  1, 0, 0, 32'h1234_5000, 1, 32'h1234_5097, 32'd24);
        send(9,  1, 0, 0, 32'd4,        1, 32'h0040_00EF, 32'd28);
        send(10, 1, 1, 0, 32'd0,        1, 32'h0000_80E7, 32'd32);
        // model-only patterns: negative S/B offsets, J offset with bit 11, AND
        send(5,  0, 3, 4, 32'hFFFF_FFFC, 0, '0, '0);
        send(6,  0, 5, 6, 32'hFFFF_FFF8, 0, '0, '0);
        send(9,  2, 0, 0, 32'h0000_0FFE, 0, '0, '0);
        send(2,  7, 8, 9, 32'd0,        0, '0, '0);

        // backpressure: held word must stay put while ready is low
        idle();
        instr_ready = 1'b0;
        send(0, 0, 1, 2, 32'd0, 1, 32'h0020_8033, 32'd52);
        drive(1, 0, 1, 2, 32'd0, 1, 32'h4020_8033, 32'd56);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req_ready", 32'(req_ready),   32'd0);
            check("stall_word",      instr_word,       32'h0020_8033);
            check("stall_addr",      instr_addr,       32'd52);
            check("stall_count",     32'(instr_count), 32'd13);
        end
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_accept();
        @(negedge clk);
        check("release_count", 32'(instr_count), 32'd14);
        check("release_word",  instr_word,       32'h4020_8033);

        // address load together with an accept, then wrap to zero
        send(0, 0, 1, 2, 32'd0, 1, 32'h0020_8033, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        send(3, 1, 1, 0, 32'd2, 1, 32'h0020_8093, 32'h0000_0000);
        send(15, 3, 4, 5, 32'h55, 1, 32'h0000_0013, 32'h0000_0004);
        @(negedge clk);
        @(negedge clk);
        check("illegal_pulses", 32'(ill_seen), 32'd1);

        // address load alone while a word is held
        idle();
        instr_ready = 1'b0;
        send(4, 1, 0, 0, 32'd2, 1, 32'h0020_2083, 32'd8);
        addr_load = 1'b1;
        addr_value = 32'h100;
        idle();
        addr_load = 1'b0;
        @(negedge clk);
        check("held_addr_after_load", instr_addr, 32'd8);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        send(6, 0, 1, 2, 32'd0, 1, 32'h0020_8063, 32'h100);

`ifdef ENC_RANGE_CHECK_EN
        send(3, 1, 1, 0, 32'd2048, 1, 32'h0000_0013, 32'h104);
        @(negedge clk);
        check("err_range_set", 32'(err_range), 32'd1);
`endif

        // reset while a word is held drops it
        idle();
        instr_ready = 1'b0;
        send(0, 0, 1, 2, 32'd0, 0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid",  32'(instr_valid), 32'd0);
        check("midrst_count",  32'(instr_count), 32'd0);
        check("midrst_addr",   instr_addr,       32'h0);
        check("midrst_range",  32'(err_range),   32'd0);
        check("dropped_words", 32'(lit_q.size()), 32'd1);
        lit_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        instr_ready = 1'b1;
        send(0, 0, 1, 2, 32'd0, 1, 32'h0020_8033, 32'd0);
        repeat (3) idle();
        check("all_words_delivered", 32'(lit_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
